mem_port_arbiter: RTL and testbench

//  Shares the single unified instruction/data memory port (ROM below 0x400, RAM from 0x400)

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_rr_arb.sv | 20 ++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified memory port controller.
package mem_ctrl_pkg;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Grant encoding produced by the arbitration cell
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    // Default bus widths
    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    // Width of a down-counter that must hold values 0 .. cycles-1
    function automatic int cntWidth(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way arbitration cell: the data port wins unless fetch is also asking
// and fetch did not get the previous grant, so contention alternates.
module mem_rr_arb
    import mem_ctrl_pkg::*;
(
    input  logic dm_req,
    input  logic if_req,
    input  logic last_if,
    output logic grant
);

    // Pick the winner from the current requests and the previous grant
    always_comb begin
        grant = GRANT_IF;
        if (dm_req && (!if_req || last_if)) begin
            grant = GRANT_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM stage.
// Each access holds the latched address for ACCESS_CYCLES cycles, then the
// winner gets a single-cycle ready pulse; read data is registered per port.
module mem_port_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = DEFAULT_ADDR_W,
    parameter int DATA_W        = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_rd_en,
    input  logic              dm_wr_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W    = cntWidth(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t            state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              lastIf_q,  lastIf_d;
    logic              winDm_q,   winDm_d;
    logic              isWrite_q, isWrite_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] ifRdata_q, ifRdata_d;
    logic [DATA_W-1:0] dmRdata_q, dmRdata_d;

    logic dmReq;
    logic anyReq;
    logic grant;
    logic finalCycle;

    assign dmReq      = dm_rd_en | dm_wr_en;
    assign anyReq     = dmReq | if_req;
    assign finalCycle = (state_q == ACCESS) && (cnt_q == '0);

    mem_rr_arb uArb (
        .dm_req  (dmReq),
        .if_req  (if_req),
        .last_if (lastIf_q),
        .grant   (grant)
    );

    // Next-state logic: grant and latch in IDLE, count down through ACCESS,
    // capture read data on the last ACCESS cycle, pulse ready in RESP
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lastIf_d  = lastIf_q;
        winDm_d   = winDm_q;
        isWrite_d = isWrite_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ifRdata_d = ifRdata_q;
        dmRdata_d = dmRdata_q;

        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d  = ACCESS;
                    cnt_d    = CNT_LOAD;
                    winDm_d  = (grant == GRANT_DM);
                    lastIf_d = (grant == GRANT_IF);
                    if (grant == GRANT_DM) begin
                        isWrite_d = dm_wr_en;
                        addr_d    = dm_addr;
                        wdata_d   = dm_wdata;
                    end else begin
                        isWrite_d = 1'b0;
                        addr_d    = if_addr;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!isWrite_q) begin
                        if (winDm_q) begin
                            dmRdata_d = mem_rdata;
                        end else begin
                            ifRdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lastIf_q  <= 1'b1;
            winDm_q   <= 1'b0;
            isWrite_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ifRdata_q <= '0;
            dmRdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lastIf_q  <= lastIf_d;
            winDm_q   <= winDm_d;
            isWrite_q <= isWrite_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ifRdata_q <= ifRdata_d;
            dmRdata_q <= dmRdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = (state_q == ACCESS) && !isWrite_q;
    assign mem_we    = finalCycle && isWrite_q;
    assign if_ready  = (state_q == RESP) && !winDm_q;
    assign dm_ready  = (state_q == RESP) && winDm_q;
    assign if_rdata  = ifRdata_q;
    assign dm_rdata  = dmRdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a transaction-level
// reference model (arbitration rule, latency, word memory image).
module tb_mem_port_arbiter;

    localparam int AC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] ifRdata;
    logic        ifReady;
    logic        dmRdEn;
    logic        dmWrEn;
    logic [31:0] dmAddr;
    logic [31:0] dmWdata;
    logic [31:0] dmRdata;
    logic        dmReady;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memRe;
    logic        memWe;
    logic [31:0] memRdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] envMem [0:511];
    logic [31:0] refMem [0:511];
    bit          lastIfRef;
    logic [31:0] ifRdataRef;
    logic [31:0] dmRdataRef;
    bit          lastWinDm;
    bit          hadRequest;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (ifReq),
        .if_addr   (ifAddr),
        .if_rdata  (ifRdata),
        .if_ready  (ifReady),
        .dm_rd_en  (dmRdEn),
        .dm_wr_en  (dmWrEn),
        .dm_addr   (dmAddr),
        .dm_wdata  (dmWdata),
        .dm_rdata  (dmRdata),
        .dm_ready  (dmReady),
        .mem_addr  (memAddr),
        .mem_wdata (memWdata),
        .mem_re    (memRe),
        .mem_we    (memWe),
        .mem_rdata (memRdata)
    );

    function automatic logic [31:0] seedWord(input int i);
        if (i == 0) return 32'hE3A00005;
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    // Memory behind the port: combinational read, write on strobe, reloaded on reset
    assign memRdata = envMem[memAddr[10:2]];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) envMem[i] <= seedWord(i);
        end else if (memWe) begin
            envMem[memAddr[10:2]] <= memWdata;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < 512; i++) refMem[i] = seedWord(i);
        lastIfRef  = 1'b1;
        ifRdataRef = 32'h0;
        dmRdataRef = 32'h0;
    endtask

    task automatic clearRequests();
        ifReq  = 1'b0;
        dmRdEn = 1'b0;
        dmWrEn = 1'b0;
    endtask

    task automatic newIfRequest();
        ifReq  = ($urandom_range(0, 3) != 0);
        ifAddr = 32'($urandom_range(0, 511)) << 2;
    endtask

    task automatic newDmRequest();
        int op;
        op      = int'($urandom_range(0, 3));
        dmRdEn  = (op == 1) || (op == 3);
        dmWrEn  = (op == 2) || (op == 3);
        dmWdata = $urandom;
        if (dmWrEn) dmAddr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
        else        dmAddr = 32'($urandom_range(0, 511)) << 2;
    endtask

    // One grant: predict winner, latency, strobes and read data, then observe
    task automatic applyStimulus(input bit fromResp, input bit dropWinner);
        bit          dmReqM, winDm, isWr, gotIf, gotDm;
        logic [31:0] a, wd;
        int          expEdges, readyEdge, weCount, reCount, idx;
        dmReqM = dmRdEn | dmWrEn;
        hadRequest = ifReq | dmReqM;
        if (!hadRequest) begin
            repeat (3) begin
                @(posedge clk); #1;
                checkOutput("idle_re", 32'(memRe), 32'h0);
                checkOutput("idle_we", 32'(memWe), 32'h0);
            end
            return;
        end
        winDm     = dmReqM && (!ifReq || lastIfRef);
        lastIfRef = !winDm;
        lastWinDm = winDm;
        isWr      = winDm && dmWrEn;
        a         = winDm ? dmAddr : ifAddr;
        wd        = dmWdata;
        expEdges  = AC + 1 + (fromResp ? 1 : 0);
        readyEdge = 0;
        weCount   = 0;
        reCount   = 0;
        gotIf     = 1'b0;
        gotDm     = 1'b0;
        for (int e = 1; e <= expEdges + 4 && readyEdge == 0; e++) begin
            @(posedge clk); #1;
            if (dropWinner && e == (fromResp ? 2 : 1)) begin
                if (winDm) begin
                    dmRdEn = 1'b0; dmWrEn = 1'b0; dmAddr = $urandom; dmWdata = $urandom;
                end else begin
                    ifReq = 1'b0; ifAddr = $urandom;
                end
            end
            if (memWe) begin
                weCount++;
                checkOutput("we_addr", memAddr, a);
                checkOutput("we_data", memWdata, wd);
            end
            if (memRe) begin
                reCount++;
                checkOutput("re_addr", memAddr, a);
            end
            if (fromResp && e == 1) begin
                checkOutput("ready_width", {30'b0, ifReady, dmReady}, 32'h0);
            end else if (ifReady || dmReady) begin
                readyEdge = e;
                gotIf = ifReady;
                gotDm = dmReady;
            end
        end
        checkOutput("ready_latency", 32'(readyEdge), 32'(expEdges));
        checkOutput("if_ready", 32'(gotIf), 32'(!winDm));
        checkOutput("dm_ready", 32'(gotDm), 32'(winDm));
        checkOutput("we_count", 32'(weCount), isWr ? 32'h1 : 32'h0);
        checkOutput("re_count", 32'(reCount), isWr ? 32'h0 : 32'(AC));
        idx = int'(a[10:2]);
        if (!winDm)    ifRdataRef  = refMem[idx];
        else if (isWr) refMem[idx] = wd;
        else           dmRdataRef  = refMem[idx];
        checkOutput("if_rdata", ifRdata, ifRdataRef);
        checkOutput("dm_rdata", dmRdata, dmRdataRef);
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearRequests();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_mem_addr", memAddr, 32'h0);
        checkOutput("rst_mem_wdata", memWdata, 32'h0);
        checkOutput("rst_ctrl", {28'b0, memRe, memWe, ifReady, dmReady}, 32'h0);
        checkOutput("rst_if_rdata", ifRdata, 32'h0);
        checkOutput("rst_dm_rdata", dmRdata, 32'h0);
        rst = 1'b0;
        resetModel();
    endtask

    initial begin
        bit fromResp;
        rst = 1'b1; ifAddr = 0; dmAddr = 0; dmWdata = 0;
        clearRequests();
        lastWinDm = 1'b0; hadRequest = 1'b0;

        // Reset, then idle with no requests
        doReset();
        applyStimulus(1'b0, 1'b0);

        // Single fetch from ROM word 0
        ifReq = 1'b1; ifAddr = 32'h0;
        applyStimulus(1'b0, 1'b0);
        checkOutput("fetch_data", ifRdata, 32'hE3A00005);

        // Contention: four grants with both requests held
        ifAddr = 32'h8; dmRdEn = 1'b1; dmAddr = 32'h404;
        for (int g = 0; g < 4; g++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("contend_order", 32'(lastWinDm), (g % 2 == 0) ? 32'h1 : 32'h0);
        end

        // Store then load at the start of RAM
        clearRequests();
        dmWrEn = 1'b1; dmAddr = 32'h400; dmWdata = 32'hDEADBEEF;
        applyStimulus(1'b1, 1'b0);
        dmWrEn = 1'b0; dmRdEn = 1'b1;
        applyStimulus(1'b1, 1'b0);
        checkOutput("load_data", dmRdata, 32'hDEADBEEF);

        // Read and write together behave as a store
        dmRdEn = 1'b1; dmWrEn = 1'b1; dmAddr = 32'h404; dmWdata = 32'hCAFEF00D;
        applyStimulus(1'b1, 1'b0);
        checkOutput("rw_keep_rdata", dmRdata, 32'hDEADBEEF);

        // Reset during the first ACCESS cycle of a store
        clearRequests();
        @(posedge clk); #1;
        dmWrEn = 1'b1; dmAddr = 32'h408; dmWdata = 32'h12345678;
        @(posedge clk); #1;
        checkOutput("abort_in_access", 32'(memRe | memWe), 32'h0);
        checkOutput("abort_addr", memAddr, 32'h408);
        rst = 1'b1;
        @(posedge clk); #1;
        dmWrEn = 1'b0;
        checkOutput("abort_ctrl", {29'b0, memRe, memWe, dmReady}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        resetModel();
        repeat (3) begin
            @(posedge clk); #1;
            checkOutput("abort_quiet", {29'b0, memWe, dmReady, ifReady}, 32'h0);
        end

        // After reset the data port must win first contention
        ifReq = 1'b1; ifAddr = 32'h10; dmRdEn = 1'b1; dmAddr = 32'h408;
        applyStimulus(1'b0, 1'b0);
        checkOutput("post_reset_dm_first", 32'(lastWinDm), 32'h1);
        checkOutput("abort_no_write", dmRdata, seedWord(258));

        // Randomized traffic
        clearRequests();
        @(posedge clk); #1;
        @(posedge clk); #1;
        newIfRequest();
        newDmRequest();
        fromResp = 1'b0;
        for (int t = 0; t < 250; t++) begin
            applyStimulus(fromResp, $urandom_range(0, 4) == 0);
            if (!hadRequest) begin
                newIfRequest();
                newDmRequest();
                fromResp = 1'b0;
            end else begin
                if (lastWinDm) newDmRequest();
                else           newIfRequest();
                fromResp = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
